// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and a future receiver).
// Frame sequencing states, the data width and a baud divisor helper.
package uart_pkg;

    typedef enum bit [1:0] {
        UTX_IDLE  = 2'd0,
        UTX_START = 2'd1,
        UTX_DATA  = 2'd2,
        UTX_STOP  = 2'd3
    } uart_tx_sm_t;

    localparam int unsigned UART_DATA_BITS = 8;

    // Rounded clock cycles per bit, e.g. clks_per_bit(50_000_000, 921_600) = 54.
    function automatic int unsigned clks_per_bit(
        input longint unsigned clock_hz,
        input longint unsigned baud
    );
        longint unsigned q;
        q = (clock_hz + (baud >> 1)) / baud;
        return q[31:0];
    endfunction

endpackage

// File: rtl/uart_tx_serializer_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Holding restart_i parks the counter at zero so the next bit starts aligned.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 54
) (
    input  logic clk_i,
    input  logic srst_n_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_bit_timer: CLKS_PER_BIT must be in 2..65535");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || (cnt_q == TERMINAL)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == TERMINAL) && !restart_i;

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-at-a-time 8N1/8N2 UART transmitter with registered outputs.
// Upstream paces itself on uart_tx_active; requests while busy only raise tx_overrun.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 54,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       uart_tx_send_byte,
    input  logic [7:0] uart_tx_byte,
    output logic       uart_tx_active,
    output logic       uart_tx,
    output logic       tx_done,
    output logic       tx_overrun
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic       LAST_STOP_BIT = 1'(STOP_BITS - 1);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    uart_tx_sm_t               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;
    logic                      tx_q, tx_d;
    logic                      active_q, active_d;
    logic                      done_q, done_d;
    logic                      overrun_q, overrun_d;
    logic                      bit_tick;
    logic                      timer_restart;

    // The divider is parked while idle so the start bit gets a full period.
    assign timer_restart = (state_q == UTX_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clock),
        .srst_n_i (reset_n),
        .restart_i(timer_restart),
        .tick_o   (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        active_d   = active_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (uart_tx_send_byte & active_q);

        case (state_q)
            UTX_IDLE: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                if (uart_tx_send_byte) begin
                    shift_d    = uart_tx_byte;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                    active_d   = 1'b1;
                    state_d    = UTX_START;
                end
            end
            UTX_START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    state_d = UTX_DATA;
                end
            end
            UTX_DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b1, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA_BIT) begin
                        tx_d       = 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = UTX_STOP;
                    end else begin
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            UTX_STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP_BIT) begin
                        active_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = UTX_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d     = 1'b1;
                active_d = 1'b0;
                state_d  = UTX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= UTX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            active_q   <= active_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign uart_tx        = tx_q;
    assign uart_tx_active = active_q;
    assign tx_done        = done_q;
    assign tx_overrun     = overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: a fast instance (4 clks/bit, 1 stop) and a 54 clks/bit, 2-stop instance.
module tb_uart_tx_serializer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       send;
    logic [7:0] byte_in;
    logic       active, tx, done, ov;
    logic       send2;
    logic [7:0] byte2;
    logic       active2, tx2, done2, ov2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_fast (
        .clock            (clock),
        .reset_n          (reset_n),
        .uart_tx_send_byte(send),
        .uart_tx_byte     (byte_in),
        .uart_tx_active   (active),
        .uart_tx          (tx),
        .tx_done          (done),
        .tx_overrun       (ov)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(54), .STOP_BITS(2)) u_slow (
        .clock            (clock),
        .reset_n          (reset_n),
        .uart_tx_send_byte(send2),
        .uart_tx_byte     (byte2),
        .uart_tx_active   (active2),
        .uart_tx          (tx2),
        .tx_done          (done2),
        .tx_overrun       (ov2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one request to the fast instance; returns just after the accepting edge.
    task automatic send_fast(input logic [7:0] b);
        send    = 1'b1;
        byte_in = b;
        tick();
        send    = 1'b0;
        byte_in = ~b;
    endtask

    // Walks cycles 0..39 of a fast frame, sampling the line at each bit centre.
    task automatic run_frame(input int inject_at, output logic [9:0] bits,
                             output int act_cnt, output int done_cnt, output int ov_first);
        bits     = '0;
        act_cnt  = 0;
        done_cnt = 0;
        ov_first = -1;
        for (int e = 0; e < 40; e++) begin
            if (e > 0) tick();
            if (active) act_cnt++;
            if (done) done_cnt++;
            if (ov && ov_first < 0) ov_first = e;
            if (e % 4 == 2) bits[e / 4] = tx;
            if (e == inject_at) begin
                send    = 1'b1;
                byte_in = 8'h99;
            end else begin
                send = 1'b0;
            end
        end
        send = 1'b0;
    endtask

    initial begin
        logic [9:0]  bits_a;
        logic [9:0]  bits_b;
        logic [10:0] bits11;
        int act_a, act_b, dn_a, dn_b, ovf_a, ovf_b;
        int total, k, dcnt, e, run;

        reset_n = 1'b0;
        send    = 1'b1;
        byte_in = 8'h5A;
        send2   = 1'b0;
        byte2   = 8'h00;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tx", tx, 1'b1);
            chk("rst_active", active, 1'b0);
            chk("rst_overrun", ov, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        chk("rst_tx2", tx2, 1'b1);
        chk("rst_active2", active2, 1'b0);
        reset_n = 1'b1;
        send    = 1'b0;
        tick();
        chk("post_rst_tx", tx, 1'b1);
        chk("post_rst_active", active, 1'b0);

        // Single byte 0xA5.
        send_fast(8'hA5);
        chk("a5_start_edge", tx, 1'b0);
        run_frame(-1, bits_a, act_a, dn_a, ovf_a);
        chk("a5_bits", 32'(bits_a), 32'h34A);
        chk("a5_active_cnt", act_a, 40);
        chk("a5_done_early", dn_a, 0);
        tick();
        chk("a5_active_end", active, 1'b0);
        chk("a5_done", done, 1'b1);
        chk("a5_idle_line", tx, 1'b1);
        tick();
        chk("a5_done_once", done, 1'b0);
        chk("a5_no_overrun", ov, 1'b0);

        // Back-to-back 0x00 then 0xFF in the tx_done cycle.
        send_fast(8'h00);
        run_frame(-1, bits_a, act_a, dn_a, ovf_a);
        tick();
        chk("b2b_done1", done, 1'b1);
        chk("b2b_gap_line", tx, 1'b1);
        send    = 1'b1;
        byte_in = 8'hFF;
        tick();
        send    = 1'b0;
        byte_in = 8'h00;
        chk("b2b_start2", tx, 1'b0);
        chk("b2b_active2", active, 1'b1);
        total = 41;
        run_frame(-1, bits_b, act_b, dn_b, ovf_b);
        total += 39;
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        total += k;
        chk("b2b_total", total, 81);
        chk("b2b_bits00", 32'(bits_a), 32'h200);
        chk("b2b_bitsFF", 32'(bits_b), 32'h3FE);
        chk("b2b_active_cnt2", act_b, 40);
        chk("b2b_no_overrun", ov, 1'b0);
        tick();

        // Overrun: second request 10 cycles into a 0x3C frame.
        send_fast(8'h3C);
        run_frame(10, bits_a, act_a, dn_a, ovf_a);
        chk("ovr_first_cycle", ovf_a, 11);
        chk("ovr_bits", 32'(bits_a), 32'h278);
        chk("ovr_active_cnt", act_a, 40);
        tick();
        chk("ovr_done", done, 1'b1);
        chk("ovr_sticky_end", ov, 1'b1);
        tick();
        tick();
        chk("ovr_sticky_idle", ov, 1'b1);
        chk("ovr_no_restart", active, 1'b0);

        // Reset during D3 of 0xF0.
        send_fast(8'hF0);
        for (int i = 1; i <= 17; i++) tick();
        chk("mid_d3_line", tx, 1'b0);
        chk("mid_overrun_pre", ov, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_active", active, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_overrun", ov, 1'b0);
        reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || active) dcnt++;
        end
        chk("mid_quiet", dcnt, 0);
        send_fast(8'hF0);
        run_frame(-1, bits_a, act_a, dn_a, ovf_a);
        chk("mid_new_bits", 32'(bits_a), 32'h3E0);
        chk("mid_new_active", act_a, 40);
        tick();
        chk("mid_new_done", done, 1'b1);

        // Two stop bits at 54 clocks per bit, byte 0x55.
        send2 = 1'b1;
        byte2 = 8'h55;
        tick();
        send2 = 1'b0;
        byte2 = 8'hAA;
        bits11 = '0;
        e   = 0;
        run = 0;
        while (active2 && e < 2000) begin
            if (e % 54 == 27 && e / 54 < 11) bits11[e / 54] = tx2;
            run = tx2 ? run + 1 : 0;
            tick();
            e++;
        end
        chk("s2_active_cnt", e, 594);
        chk("s2_stop_high", run, 108);
        chk("s2_bits", 32'(bits11), 32'h6AA);
        chk("s2_done", done2, 1'b1);
        chk("s2_no_overrun", ov2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
